// File: rtl/affine_blk4x4_sched_if.sv
// Handshake bundle between the affine ME controller (master) and the
// current-block 4x4 sub-block sequencer (slave).
interface affine_blk4x4_sched_if;
    logic              start;
    logic [8:0]        pu_w;
    logic [8:0]        pu_h;
    logic              abort;
    logic              load_req;
    logic              load_done;
    logic signed [7:0] blk_x;
    logic signed [7:0] blk_y;
    logic              blk_issue;
    logic              blk_first;
    logic              blk_last;
    logic              blk_ack;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
        output start, pu_w, pu_h, abort, load_done, blk_ack,
        input  load_req, blk_x, blk_y, blk_issue, blk_first, blk_last,
               busy, done, cfg_err
    );

    modport slave (
        input  start, pu_w, pu_h, abort, load_done, blk_ack,
        output load_req, blk_x, blk_y, blk_issue, blk_first, blk_last,
               busy, done, cfg_err
    );
endinterface

// File: rtl/affine_blk4x4_sched.sv
// Walks a prediction unit's 4x4 sub-blocks in raster order, issuing one at a
// time and waiting for a per-sub-block acknowledge; all outputs registered.
module affine_blk4x4_sched #(
    parameter int MAX_DIM = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    affine_blk4x4_sched_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    localparam logic [8:0] MAX_DIM_C = 9'(MAX_DIM);

    state_t     state_q;
    logic [8:0] w_q;
    logic [8:0] h_q;
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic       load_req_q;
    logic       issue_q;
    logic       first_q;
    logic       last_q;
    logic       busy_q;
    logic       done_q;
    logic       cfg_err_q;

    logic       size_ok;
    logic       row_end;
    logic       at_last;
    logic [7:0] x_d;
    logic [7:0] y_d;
    logic       first_d;
    logic       last_d;

    assign size_ok = (bus.pu_w[1:0] == 2'b00) && (bus.pu_w >= 9'd8) && (bus.pu_w <= MAX_DIM_C)
                  && (bus.pu_h[1:0] == 2'b00) && (bus.pu_h >= 9'd8) && (bus.pu_h <= MAX_DIM_C);

    // Position tests are made against the latched size so mid-PU size changes are ignored.
    assign row_end = ({1'b0, x_q} == (w_q - 9'd4));
    assign at_last = row_end && ({1'b0, y_q} == (h_q - 9'd4));

    always_comb begin
        x_d = x_q + 8'd4;
        y_d = y_q;
        if (row_end) begin
            x_d = 8'd0;
            y_d = y_q + 8'd4;
        end
        first_d = (x_d == 8'd0) && (y_d == 8'd0);
        last_d  = ({1'b0, x_d} == (w_q - 9'd4)) && ({1'b0, y_d} == (h_q - 9'd4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            load_req_q <= 1'b0;
            issue_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            // Every pulse output defaults low; the case below raises it for exactly one cycle.
            load_req_q <= 1'b0;
            issue_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;

            if (bus.abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            if (size_ok) begin
                                w_q        <= bus.pu_w;
                                h_q        <= bus.pu_h;
                                x_q        <= '0;
                                y_q        <= '0;
                                load_req_q <= 1'b1;
                                busy_q     <= 1'b1;
                                state_q    <= S_LOAD;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (bus.load_done) begin
                            issue_q <= 1'b1;
                            first_q <= (x_q == 8'd0) && (y_q == 8'd0);
                            last_q  <= at_last;
                            state_q <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        state_q <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        if (bus.blk_ack) begin
                            if (at_last) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                x_q     <= x_d;
                                y_q     <= y_d;
                                issue_q <= 1'b1;
                                first_q <= first_d;
                                last_q  <= last_d;
                                state_q <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.load_req  = load_req_q;
    assign bus.blk_x     = $signed(x_q);
    assign bus.blk_y     = $signed(y_q);
    assign bus.blk_issue = issue_q;
    assign bus.blk_first = first_q;
    assign bus.blk_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_affine_blk4x4_sched.sv
// Self-checking bench for affine_blk4x4_sched: table vectors, random PUs
// against a raster-order model, and hand sequences for abort/reset/throughput.
module tb_affine_blk4x4_sched;

    logic clk;
    logic rst_n;

    affine_blk4x4_sched_if bus ();

    affine_blk4x4_sched #(.MAX_DIM(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit f;
        bit l;
    } blk_t;

    typedef struct {
        int w;
        int h;
        int load_lat;
        int ack_lat;
        bit busy_start;
        bit legal;
        int n_blk;
    } vec_t;

    int checks;
    int errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_legal(input int w, input int h);
        return (w % 4 == 0) && (w >= 8) && (w <= 128) && (h % 4 == 0) && (h >= 8) && (h <= 128);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load_req"}, int'(bus.load_req), 0);
        chk({tag, "_blk_x"}, int'(bus.blk_x), 0);
        chk({tag, "_blk_y"}, int'(bus.blk_y), 0);
        chk({tag, "_blk_issue"}, int'(bus.blk_issue), 0);
        chk({tag, "_blk_first"}, int'(bus.blk_first), 0);
        chk({tag, "_blk_last"}, int'(bus.blk_last), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_cfg_err"}, int'(bus.cfg_err), 0);
    endtask

    // Runs one PU from start to completion, comparing every issue against the raster model.
    task automatic run_pu(input int w, input int h, input int load_lat, input int ack_lat,
                          input bit busy_start, input bit exp_legal, input int exp_n);
        blk_t exp_q[$];
        int   n;
        bit   fin;
        for (int y = 0; y < h; y += 4)
            for (int x = 0; x < w; x += 4)
                exp_q.push_back('{x, y, (x == 0 && y == 0), (x == w - 4 && y == h - 4)});

        bus.pu_w  = 9'(w);
        bus.pu_h  = 9'(h);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.pu_w  = 9'($urandom);
        bus.pu_h  = 9'($urandom);

        if (!exp_legal) begin
            chk("cfg_err_pulse", int'(bus.cfg_err), 1);
            chk("illegal_busy", int'(bus.busy), 0);
            chk("illegal_load_req", int'(bus.load_req), 0);
            tick();
            chk("cfg_err_one_cycle", int'(bus.cfg_err), 0);
            chk("illegal_busy_after", int'(bus.busy), 0);
            $display("PU %0dx%0d rejected", w, h);
            return;
        end

        chk("start_cfg_err", int'(bus.cfg_err), 0);
        chk("start_busy", int'(bus.busy), 1);
        chk("start_load_req", int'(bus.load_req), 1);
        for (int i = 0; i < load_lat; i++) begin
            tick();
            chk("load_req_single", int'(bus.load_req), 0);
            chk("no_issue_in_load", int'(bus.blk_issue), 0);
        end
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;

        n   = 0;
        fin = 1'b0;
        for (int g = 0; g < 1100 && !fin; g++) begin
            if (!bus.blk_issue) begin
                chk("issue_present", 0, 1);
                break;
            end
            if (n < exp_q.size()) begin
                chk("blk_x", int'(bus.blk_x), exp_q[n].x);
                chk("blk_y", int'(bus.blk_y), exp_q[n].y);
                chk("blk_first", int'(bus.blk_first), int'(exp_q[n].f));
                chk("blk_last", int'(bus.blk_last), int'(exp_q[n].l));
            end
            n++;
            if (busy_start && n == 2) begin
                bus.start = 1'b1;
                bus.pu_w  = 9'd16;
                bus.pu_h  = 9'd16;
            end
            for (int j = 0; j < ack_lat; j++) begin
                tick();
                bus.start = 1'b0;
                chk("issue_single_cycle", int'(bus.blk_issue), 0);
                chk("coords_hold_x", int'(bus.blk_x), (n <= exp_q.size()) ? exp_q[n-1].x : 0);
            end
            bus.blk_ack = 1'b1;
            tick();
            bus.blk_ack = 1'b0;
            if (bus.done) fin = 1'b1;
        end

        chk("issue_count", n, exp_n);
        chk("done_seen", int'(fin), 1);
        chk("busy_during_done", int'(bus.busy), 1);
        tick();
        chk("done_one_cycle", int'(bus.done), 0);
        chk("busy_after_done", int'(bus.busy), 0);
        chk("coords_kept_x", int'(bus.blk_x), w - 4);
        chk("coords_kept_y", int'(bus.blk_y), h - 4);
        $display("PU %0dx%0d load_lat %0d ack_lat %0d issues %0d done %0d", w, h, load_lat, ack_lat, n, fin);
    endtask

    // Starts an 8x8 PU and stops once the k-th issue (1-based) has just been observed.
    task automatic run_to_issue(input int k);
        bus.pu_w  = 9'd8;
        bus.pu_h  = 9'd8;
        bus.start = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        for (int i = 1; i < k; i++) begin
            tick();
            bus.blk_ack = 1'b1;
            tick();
            bus.blk_ack = 1'b0;
        end
        chk("partial_issue", int'(bus.blk_issue), 1);
    endtask

    vec_t vecs[12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen_issue;
        int   seen_done;
        int   cyc;
        int   icyc[$];
        blk_t got[$];
        blk_t ref_q[$];

        checks = 0;
        errors = 0;

        vecs[0]  = '{8,   8,   2, 3, 1'b0, 1'b1, 4};
        vecs[1]  = '{16,  8,   0, 1, 1'b0, 1'b1, 8};
        vecs[2]  = '{6,   8,   0, 1, 1'b0, 1'b0, 0};
        vecs[3]  = '{8,   132, 0, 1, 1'b0, 1'b0, 0};
        vecs[4]  = '{10,  8,   0, 1, 1'b0, 1'b0, 0};
        vecs[5]  = '{12,  20,  1, 2, 1'b1, 1'b1, 15};
        vecs[6]  = '{128, 8,   0, 1, 1'b0, 1'b1, 64};
        vecs[7]  = '{8,   128, 1, 1, 1'b1, 1'b1, 64};
        vecs[8]  = '{4,   8,   0, 1, 1'b0, 1'b0, 0};
        vecs[9]  = '{256, 8,   0, 1, 1'b0, 1'b0, 0};
        vecs[10] = '{128, 128, 0, 1, 1'b0, 1'b1, 1024};
        vecs[11] = '{8,   8,   0, 2, 1'b1, 1'b1, 4};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.pu_w      = '0;
        bus.pu_h      = '0;
        bus.abort     = 1'b0;
        bus.load_done = 1'b0;
        bus.blk_ack   = 1'b0;
        #22;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i])
            run_pu(vecs[i].w, vecs[i].h, vecs[i].load_lat, vecs[i].ack_lat,
                   vecs[i].busy_start, vecs[i].legal, vecs[i].n_blk);

        // 16x8 with blk_ack held high: one issue every two cycles.
        for (int y = 0; y < 8; y += 4)
            for (int x = 0; x < 16; x += 4)
                ref_q.push_back('{x, y, (x == 0 && y == 0), (x == 12 && y == 4)});
        bus.blk_ack = 1'b1;
        bus.pu_w    = 9'd16;
        bus.pu_h    = 9'd8;
        bus.start   = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
        seen_done = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (bus.blk_issue) begin
                icyc.push_back(cyc);
                got.push_back('{int'(bus.blk_x), int'(bus.blk_y), bus.blk_first, bus.blk_last});
            end
            if (bus.done) begin
                seen_done = 1;
                break;
            end
            tick();
        end
        bus.blk_ack = 1'b0;
        chk("tput_count", got.size(), 8);
        chk("tput_done", seen_done, 1);
        for (int i = 0; i < got.size() && i < 8; i++) begin
            chk("tput_x", got[i].x, ref_q[i].x);
            chk("tput_y", got[i].y, ref_q[i].y);
            chk("tput_first", int'(got[i].f), int'(ref_q[i].f));
            chk("tput_last", int'(got[i].l), int'(ref_q[i].l));
            if (i > 0) chk("tput_spacing", icyc[i] - icyc[i-1], 2);
        end
        tick();
        chk("tput_busy_low", int'(bus.busy), 0);
        $display("PU 16x8 ack tied high issues %0d done %0d", got.size(), seen_done);

        // Abort in WAIT_ACK of the third sub-block, coinciding with blk_ack.
        run_to_issue(3);
        chk("abort_third_x", int'(bus.blk_x), 0);
        chk("abort_third_y", int'(bus.blk_y), 4);
        tick();
        bus.blk_ack = 1'b1;
        bus.abort   = 1'b1;
        tick();
        bus.blk_ack = 1'b0;
        bus.abort   = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_issue", int'(bus.blk_issue), 0);
        chk("abort_done", int'(bus.done), 0);
        seen_issue = 0;
        seen_done  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_issue += int'(bus.blk_issue);
            seen_done  += int'(bus.done);
        end
        chk("abort_no_issue", seen_issue, 0);
        chk("abort_no_done", seen_done, 0);
        $display("abort in WAIT_ACK of sub-block 3");
        run_pu(8, 8, 0, 1, 1'b0, 1'b1, 4);

        // Abort beats start in IDLE, for both legal and illegal sizes.
        bus.pu_w  = 9'd6;
        bus.pu_h  = 9'd8;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        chk("abort_idle_cfg_err", int'(bus.cfg_err), 0);
        bus.pu_w = 9'd8;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_idle_busy", int'(bus.busy), 0);
        chk("abort_idle_load_req", int'(bus.load_req), 0);
        $display("abort with start in IDLE");

        // Asynchronous reset during LOAD.
        bus.pu_w  = 9'd8;
        bus.pu_h  = 9'd8;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("pre_rst_load_busy", int'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_load");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset during LOAD");
        run_pu(8, 8, 1, 1, 1'b0, 1'b1, 4);

        // Asynchronous reset during WAIT_ACK of sub-block (4,0).
        run_to_issue(2);
        chk("pre_rst_wait_x", int'(bus.blk_x), 4);
        tick();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset during WAIT_ACK");
        run_pu(8, 8, 0, 2, 1'b0, 1'b1, 4);

        // Randomized PUs checked against the model.
        for (int r = 0; r < 16; r++) begin
            int w;
            int h;
            bit lg;
            if ($urandom_range(0, 3) == 0) w = int'($urandom_range(0, 140));
            else                           w = 4 * int'($urandom_range(1, 12));
            if ($urandom_range(0, 3) == 0) h = int'($urandom_range(0, 140));
            else                           h = 4 * int'($urandom_range(1, 12));
            lg = model_legal(w, h);
            run_pu(w, h, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                   1'($urandom_range(0, 1)), lg, lg ? (w / 4) * (h / 4) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/affine_blk4x4_sched.md
# affine_blk4x4_sched

Sequencer for the affine motion-estimation current-block path.
- Accepts a prediction-unit (PU) size.
- Requests the current-block load.
- Walks the PU's 4x4 sub-blocks in raster order, issuing one sub-block at a time to the current-block reader and cost datapath.
- Waits for a per-sub-block acknowledge before issuing the next sub-block.
- Flags the first and last sub-blocks and signals PU completion.

## Interface
- MAX_DIM, 128: largest legal PU width/height in pixels. Must be ≤128 so coordinates fit signed 8-bit.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request. Samples pu_w/pu_h. Honoured only in IDLE.
- pu_w  in  9  PU width in pixels.
- pu_h  in  9  PU height in pixels.
- abort  in  1  synchronous cancel. Returns the block to IDLE from any state.
- load_req  out  1  one-cycle pulse requesting the current-block memory load.
- load_done  in  1  load complete. Sampled only in LOAD.
- blk_x  out  8 signed  sub-block x offset from the PU origin (multiple of 4).
- blk_y  out  8 signed  sub-block y offset from the PU origin (multiple of 4).
- blk_issue  out  1  one-cycle pulse: blk_x/blk_y valid for a new sub-block.
- blk_first  out  1  high with blk_issue for sub-block (0,0).
- blk_last  out  1  high with blk_issue for sub-block (pu_w-4, pu_h-4).
- blk_ack  in  1  downstream finished the issued sub-block. Sampled only in WAIT_ACK.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last sub-block is acknowledged.
- cfg_err  out  1  one-cycle pulse on start with an illegal size.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT_ACK, DONE.
- **IDLE**
  - On start, the size is legal when pu_w and pu_h are each a multiple of 4 in [8, MAX_DIM].
  - Legal size: latch the size, clear x/y to 0, go to LOAD.
  - Illegal size: pulse cfg_err and stay in IDLE.
- **LOAD**
  - load_req is high only in the first LOAD cycle.
  - On load_done, go to ISSUE.
  - load_done seen in the same cycle as load_req is accepted.
- **ISSUE**: one cycle.
  - blk_issue = 1.
  - blk_first = (x==0 && y==0).
  - blk_last = (x==w-4 && y==h-4).
  - Go to WAIT_ACK.
- **WAIT_ACK**: on blk_ack:
  - If the current sub-block is last, go to DONE.
  - Otherwise, if x==w-4, set x=0 and y+=4. Else x+=4.
  - Then go to ISSUE.
- **DONE**: pulse done for one cycle, then go to IDLE.
- **Coordinates**
  - blk_x/blk_y are registered.
  - They change only on the WAIT_ACK→ISSUE transition.
  - They hold stable from blk_issue until the next blk_issue. Downstream may register addresses at any point in that window.
  - After DONE they keep their last values until the next legal start.
- **Sizes**: latched w/h are used for the whole PU. Changes on pu_w/pu_h while busy are ignored.
- **Sub-block count**: (w/4)*(h/4) blk_issue pulses per PU. Exactly one has blk_first, exactly one has blk_last.
- **Simultaneous events**
  - start while busy: ignored.
  - abort has priority over every other input, including blk_ack, load_done and start in IDLE.
  - abort forces IDLE next cycle with no done or cfg_err pulse, and clears any pending pulse outputs.
- **Reset**: asynchronous.
  - State goes to IDLE.
  - Every output goes to 0: load_req, blk_x, blk_y, blk_issue, blk_first, blk_last, busy, done, cfg_err.
  - Latched size clears to 0.
  - Reset mid-PU discards all progress.

## Timing
- All outputs are registered, with no combinational input→output paths.
- start sampled at edge T:
  - busy and load_req high in cycle T+1.
  - cfg_err high in cycle T+1 for an illegal size.
- load_done sampled at edge T: blk_issue high in T+1.
- blk_ack sampled at edge T in WAIT_ACK:
  - Next blk_issue with new coordinates in T+1.
  - Or done in T+1 after the last sub-block.
- blk_ack asserted during the ISSUE cycle is not sampled.
- Maximum throughput is 1 sub-block per 2 cycles, with blk_ack held high.
- busy falls in the cycle after done.
- A new start is accepted in the cycle busy is low.

## Test plan
- **8x8 PU**: start with load_done 2 cycles later, and blk_ack 3 cycles after each issue.
  - Issues (0,0)F, (4,0), (0,4), (4,4)L.
  - One done pulse, then busy low.
- **16x8 PU with blk_ack tied high**:
  - 8 issues spaced exactly 2 cycles apart.
  - Row wrap (12,0)→(0,4).
  - Last is (12,4).
- **Illegal sizes**: start with pu_w=6, then pu_h=132, then pu_w=10.
  - Each gives one cfg_err pulse.
  - busy and load_req stay 0.
- **Start while busy**: a second start mid-PU with a different size is ignored. The original sequence completes unchanged.
- **abort**: abort asserted in WAIT_ACK of the third sub-block together with blk_ack.
  - Block is in IDLE next cycle.
  - No further issues, no done.
  - A new 8x8 start then runs normally.
- **Asynchronous reset mid-PU**: rst_n asserted during LOAD and during WAIT_ACK.
  - All outputs are 0 immediately.
  - After release, a new start runs from (0,0) with blk_first.
